// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   DEFAULT_HALT_WORD : default instruction encoding that stops fetch
//   PC_STEP           : byte distance between sequential instructions
//   fetch_entry_t     : {pc, instr} pair held in the fetch buffer
//   align_pc()        : forces a PC onto a word boundary
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake.
//   if_valid       : head entry is valid
//   if_pc          : PC of the head entry
//   if_instruction : instruction word of the head entry
//   id_ready       : decode accepts the head this cycle
// master = fetch side, slave = decode side.
interface instruction_fetch_unit_if;

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        id_ready;

  modport master (output if_valid, if_pc, if_instruction, input id_ready);
  modport slave  (input if_valid, if_pc, if_instruction, output id_ready);

endinterface

// File: rtl/fetch_buffer.sv
// In-order FIFO of fetch entries.
//   clock, reset : clock and synchronous active-low reset
//   push/wr_data : enqueue one entry
//   pop          : dequeue the head entry
//   flush        : empty the buffer; overrides push and pop
//   full, empty  : occupancy flags
//   count        : number of valid entries
//   head         : oldest entry (meaningful only when !empty)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: the entry storage is deliberately not reset; count alone decides
  // which slots hold valid data, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: owns the PC, drives the instruction-cache address,
// buffers returned words and hands {pc, instruction} pairs to decode.
//   clock, reset       : clock and synchronous active-low reset
//   redirect_valid/_pc : flush and restart fetch at redirect_pc (word aligned)
//   instructionAddress : registered cache address
//   instruction        : cache read data, valid one cycle after issue
//   dec                : decode handshake (master side)
//   halted             : HALT_WORD was fetched; fetch stopped until reset/redirect
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  output logic [31:0]                      instructionAddress,
  input  logic [31:0]                      instruction,
  instruction_fetch_unit_if.master         dec,
  output logic                             halted
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          squash;

  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;
  fetch_entry_t  buf_head;
  logic          push;
  logic          pop;
  logic          issue;
  logic          halt_hit;

  // A response is enqueued the edge after its issue unless the halt that
  // arrived alongside it squashed it, or a redirect is flushing everything.
  assign push     = inflight && !squash && !redirect_valid && (!buf_full || pop);
  assign pop      = dec.if_valid && dec.id_ready && !redirect_valid;
  assign halt_hit = push && (instruction == HALT_WORD);

  // Issue only when the buffer has a slot for every outstanding word, so the
  // buffer can never overflow.
  assign issue = !halted && !redirect_valid &&
                 ((SW'(buf_count) + SW'(inflight)) < SW'(BUF_DEPTH));

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data ('{pc: req_pc, instr: instruction}),
    .pop     (pop),
    .flush   (redirect_valid),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_count),
    .head    (buf_head)
  );

  // Head fields read as zero while empty so decode never sees stale data.
  assign dec.if_valid       = !buf_empty;
  assign dec.if_pc          = buf_empty ? '0 : buf_head.pc;
  assign dec.if_instruction = buf_empty ? '0 : buf_head.instr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc           <= RESET_PC;
      instructionAddress <= RESET_PC;
      req_pc             <= RESET_PC;
      inflight           <= 1'b0;
      squash             <= 1'b0;
      halted             <= 1'b0;
    end else if (redirect_valid) begin
      // Any in-flight response is dropped; issue resumes on the next edge.
      fetch_pc <= align_pc(redirect_pc);
      inflight <= 1'b0;
      squash   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (issue) begin
        instructionAddress <= fetch_pc;
        req_pc             <= fetch_pc;
        fetch_pc           <= fetch_pc + PC_STEP;
      end
      inflight <= issue;
      // A request issued at the same edge the halt word lands is discarded.
      squash   <= issue && halt_hit;
      if (halt_hit) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized phase scored against a program-order reference model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  instruction_fetch_unit_if dec ();

  instruction_fetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .dec                (dec),
    .halted             (halted)
  );

  always #5 clock = ~clock;

  // Program image: a few fixed words, everything else a word that can never
  // equal the halt sentinel (low 12 bits are 0x013).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0000_0000: return 32'h0200_0093;
      32'h0000_0004: return 32'hFF80_0113;
      32'h0000_0020: return 32'h0083_0383;
      32'h0000_0034: return 32'hFFFF_FFFF;
      default:       return {a[21:2], 12'h013};
    endcase
  endfunction

  // One-cycle-latency memory: the word for the registered address is on the
  // bus at the following edge.
  assign instruction = mem_word(instructionAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  // Expect n consecutive program-order entries starting at start_pc.
  task automatic stream(input logic [31:0] start_pc, input int n, input int budget,
                        input bit rand_ready);
    logic [31:0] exp_pc;
    int got;
    int cyc;
    exp_pc = start_pc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clock);
      if (dec.if_valid && dec.id_ready) begin
        check("stream_pc", dec.if_pc, exp_pc);
        check("stream_instr", dec.if_instruction, mem_word(exp_pc));
        exp_pc = exp_pc + PC_STEP;
        got++;
      end
      next_cycle();
      cyc++;
      if (rand_ready) dec.id_ready = 1'($urandom_range(0, 1));
    end
    check("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] target;
    bit          halt_seen;
    bit          redir_prev;

    dec.id_ready = 1'b1;
    next_cycle();

    // Reset state, then straight-line delivery.
    do_reset();
    @(negedge clock);
    check("rst_if_valid", 32'(dec.if_valid), 32'd0);
    check("rst_if_pc", dec.if_pc, 32'h0);
    check("rst_if_instr", dec.if_instruction, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", instructionAddress, 32'h0);
    next_cycle();
    stream(32'h0, 4, 30, 1'b0);

    // Backpressure from reset: exactly two entries, address holds at 4.
    dec.id_ready = 1'b0;
    do_reset();
    repeat (6) next_cycle();
    @(negedge clock);
    check("bp_if_valid", 32'(dec.if_valid), 32'd1);
    check("bp_head_pc", dec.if_pc, 32'h0);
    check("bp_head_instr", dec.if_instruction, 32'h0200_0093);
    check("bp_addr", instructionAddress, 32'h4);
    repeat (3) next_cycle();
    @(negedge clock);
    check("bp_addr_hold", instructionAddress, 32'h4);
    next_cycle();
    dec.id_ready = 1'b1;
    stream(32'h0, 3, 30, 1'b0);

    // Redirect while full: flushed, restart at aligned 0x20.
    dec.id_ready = 1'b0;
    do_reset();
    repeat (6) next_cycle();
    do_redirect(32'h0000_0023);
    dec.id_ready = 1'b1;
    @(negedge clock);
    check("redir_if_valid", 32'(dec.if_valid), 32'd0);
    next_cycle();
    @(negedge clock);
    check("redir_addr", instructionAddress, 32'h20);
    next_cycle();
    stream(32'h20, 3, 30, 1'b0);

    // Straight-line run into the halt word at 0x34.
    do_reset();
    stream(32'h0, 14, 60, 1'b0);
    repeat (4) begin
      @(negedge clock);
      check("halt_no_more", 32'(dec.if_valid), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_addr", instructionAddress, 32'h34);
      next_cycle();
    end

    // Halt word lands together with a fresh issue: that response is squashed.
    do_redirect(32'h34);
    stream(32'h34, 1, 20, 1'b0);
    repeat (5) begin
      @(negedge clock);
      check("squash_no_more", 32'(dec.if_valid), 32'd0);
      check("squash_halted", 32'(halted), 32'd1);
      next_cycle();
    end
    do_redirect(32'h0);
    @(negedge clock);
    check("unhalt", 32'(halted), 32'd0);
    next_cycle();
    stream(32'h0, 2, 20, 1'b0);

    // Mid-stream reset with two entries buffered.
    do_reset();
    stream(32'h0, 3, 30, 1'b0);
    dec.id_ready = 1'b0;
    repeat (5) next_cycle();
    @(negedge clock);
    check("mid_full", 32'(dec.if_valid), 32'd1);
    next_cycle();
    do_reset();
    @(negedge clock);
    check("mid_if_valid", 32'(dec.if_valid), 32'd0);
    check("mid_halted", 32'(halted), 32'd0);
    check("mid_addr", instructionAddress, 32'h0);
    check("mid_if_pc", dec.if_pc, 32'h0);
    next_cycle();
    dec.id_ready = 1'b1;
    stream(32'h0, 3, 30, 1'b0);

    // Wrap around the top of the address space (low bits ignored).
    do_redirect(32'hFFFF_FFFF);
    @(negedge clock);
    check("wrap_if_valid", 32'(dec.if_valid), 32'd0);
    next_cycle();
    @(negedge clock);
    check("wrap_addr", instructionAddress, 32'hFFFF_FFFC);
    next_cycle();
    stream(32'hFFFF_FFFC, 3, 30, 1'b0);

    // Randomized ready and redirects against a program-order model.
    do_reset();
    exp_pc     = DEFAULT_RESET_PC;
    halt_seen  = 1'b0;
    redir_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      dec.id_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        target         = 32'($urandom_range(0, 63));
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      @(negedge clock);
      if (redirect_valid) begin
        exp_pc    = {redirect_pc[31:2], 2'b00};
        halt_seen = 1'b0;
      end else if (redir_prev) begin
        check("rnd_redir_empty", 32'(dec.if_valid), 32'd0);
      end else if (halt_seen) begin
        check("rnd_halt_empty", 32'(dec.if_valid), 32'd0);
        check("rnd_halted", 32'(halted), 32'd1);
      end else if (dec.if_valid && dec.id_ready) begin
        check("rnd_pc", dec.if_pc, exp_pc);
        check("rnd_instr", dec.if_instruction, mem_word(exp_pc));
        if (mem_word(exp_pc) == DEFAULT_HALT_WORD) halt_seen = 1'b1;
        exp_pc = exp_pc + PC_STEP;
      end
      redir_prev = redirect_valid;
      next_cycle();
      redirect_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
